// File: rtl/gcd_traffic_gen.sv
// Purpose: requester-side traffic generator for the GCD coprocessor; issues LCG operand pairs, folds results into a checksum.
// Latency: start handshake in cycle N -> first operands_val in N+1; last result in cycle M -> done/final checksum in M+1.
// Backpressure: operands hold while operands_rdy=0; issue stalls at MAX_OUT outstanding; result_rdy is high for the whole batch.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start_val/start_rdy   start command handshake; start_count = batch length, start_seed = LCG seed
//   operands_val/_rdy     operand pair handshake; operands_bits_A/B = low/high OPW bits of the LCG state
//   result_val/_rdy       result handshake; result_bits = GCD returned by the coprocessor
//   done                  level, high while the batch is complete
//   checksum              rotate-left-by-one then XOR of every accepted result, in order
//   err                   sticky: a result was presented with nothing outstanding
//   issued, received      per-batch request/result counters
module gcd_traffic_gen #(
  parameter int W       = 32,
  parameter int OPW     = 8,
  parameter int MAX_OUT = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_val,
  output logic         start_rdy,
  input  logic [15:0]  start_count,
  input  logic [W-1:0] start_seed,
  output logic         operands_val,
  output logic [W-1:0] operands_bits_A,
  output logic [W-1:0] operands_bits_B,
  input  logic         operands_rdy,
  input  logic         result_val,
  input  logic [W-1:0] result_bits,
  output logic         result_rdy,
  output logic         done,
  output logic [W-1:0] checksum,
  output logic         err,
  output logic [15:0]  issued,
  output logic [15:0]  received
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // MAX_OUT is at most 15, so four bits always hold the outstanding count.
  localparam int            OW        = 4;
  localparam logic [OW-1:0] MAX_OUT_L = OW'(MAX_OUT);
  localparam logic [W-1:0]  LCG_MUL   = W'(32'd1664525);
  localparam logic [W-1:0]  LCG_ADD   = W'(32'd1013904223);

  state_t        state_q, state_d;
  logic [15:0]   count_q, count_d;
  logic [W-1:0]  gen_q, gen_d;
  logic [W-1:0]  checksum_q, checksum_d;
  logic [15:0]   issued_q, issued_d;
  logic [15:0]   received_q, received_d;
  logic [OW-1:0] outst_q, outst_d;
  logic          err_q, err_d;

  logic start_fire;
  logic issue_fire;
  logic result_fire;

  // Handshake-side outputs decode registered state only, so no input reaches an output combinationally.
  assign start_rdy    = (state_q == S_IDLE) || (state_q == S_DONE);
  assign result_rdy   = (state_q == S_RUN);
  assign done         = (state_q == S_DONE);
  assign operands_val = (state_q == S_RUN) && (issued_q < count_q) && (outst_q < MAX_OUT_L);

  // Operands are slices of the registered generator state; it only advances on an accepted issue,
  // so A/B are stable for as long as the coprocessor stalls.
  assign operands_bits_A = {{(W-OPW){1'b0}}, gen_q[OPW-1:0]};
  assign operands_bits_B = {{(W-OPW){1'b0}}, gen_q[W-1:W-OPW]};

  assign checksum = checksum_q;
  assign err      = err_q;
  assign issued   = issued_q;
  assign received = received_q;

  assign start_fire  = start_val && start_rdy;
  assign issue_fire  = operands_val && operands_rdy;
  assign result_fire = result_val && result_rdy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      gen_q      <= '0;
      checksum_q <= '0;
      issued_q   <= '0;
      received_q <= '0;
      outst_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      gen_q      <= gen_d;
      checksum_q <= checksum_d;
      issued_q   <= issued_d;
      received_q <= received_d;
      outst_q    <= outst_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    gen_d      = gen_q;
    checksum_d = checksum_q;
    issued_d   = issued_q;
    received_d = received_q;
    outst_d    = outst_q;
    err_d      = err_q;

    // A result with nothing in flight is a protocol violation in any state; a new start does not clear it.
    if (result_val && (outst_q == '0)) begin
      err_d = 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_fire) begin
          count_d    = start_count;
          gen_d      = start_seed;
          checksum_d = '0;
          issued_d   = '0;
          received_d = '0;
          outst_d    = '0;
          state_d    = (start_count == 16'd0) ? S_DONE : S_RUN;
        end
      end

      S_RUN: begin
        if (issue_fire) begin
          gen_d    = gen_q * LCG_MUL + LCG_ADD;
          issued_d = issued_q + 16'd1;
        end

        if (result_fire) begin
          checksum_d = {checksum_q[W-2:0], checksum_q[W-1]} ^ result_bits;
          received_d = received_q + 16'd1;
          if ((received_q + 16'd1) == count_q) begin
            state_d = S_DONE;
          end
        end

        // Simultaneous issue and receive leave the count unchanged. A stray result with
        // nothing outstanding is flagged above and must not wrap the counter.
        if (issue_fire && !result_fire) begin
          outst_d = outst_q + 4'd1;
        end else if (!issue_fire && result_fire && (outst_q != '0)) begin
          outst_d = outst_q - 4'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_gcd_traffic_gen.sv
module tb_gcd_traffic_gen;

  localparam int W       = 32;
  localparam int MAX_OUT = 4;

  logic        clk;
  logic        reset;
  logic        start_val;
  logic        start_rdy;
  logic [15:0] start_count;
  logic [31:0] start_seed;
  logic        operands_val;
  logic [31:0] operands_bits_A;
  logic [31:0] operands_bits_B;
  logic        operands_rdy;
  logic        result_val;
  logic [31:0] result_bits;
  logic        result_rdy;
  logic        done;
  logic [31:0] checksum;
  logic        err;
  logic [15:0] issued;
  logic [15:0] received;

  int n_chk = 0;
  int n_err = 0;

  gcd_traffic_gen #(.W(W), .OPW(8), .MAX_OUT(MAX_OUT)) dut (
    .clk             (clk),
    .reset           (reset),
    .start_val       (start_val),
    .start_rdy       (start_rdy),
    .start_count     (start_count),
    .start_seed      (start_seed),
    .operands_val    (operands_val),
    .operands_bits_A (operands_bits_A),
    .operands_bits_B (operands_bits_B),
    .operands_rdy    (operands_rdy),
    .result_val      (result_val),
    .result_bits     (result_bits),
    .result_rdy      (result_rdy),
    .done            (done),
    .checksum        (checksum),
    .err             (err),
    .issued          (issued),
    .received        (received)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; outputs are stable there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] gcd_ref(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic logic [31:0] lcg_next(input logic [31:0] g);
    return g * 32'd1664525 + 32'd1013904223;
  endfunction

  function automatic logic [31:0] fold(input logic [31:0] c, input logic [31:0] r);
    return ((c << 1) | (c >> 31)) ^ r;
  endfunction

  function automatic logic [31:0] op_a(input logic [31:0] g);
    return g & 32'h0000_00FF;
  endfunction

  function automatic logic [31:0] op_b(input logic [31:0] g);
    return g >> 24;
  endfunction

  task automatic idle_inputs();
    start_val    = 1'b0;
    start_count  = '0;
    start_seed   = '0;
    operands_rdy = 1'b0;
    result_val   = 1'b0;
    result_bits  = '0;
  endtask

  task automatic start_batch(input logic [31:0] seed, input int cnt);
    start_val   = 1'b1;
    start_count = 16'(cnt);
    start_seed  = seed;
    chk("start_rdy", {31'd0, start_rdy}, 32'd1);
    tick();
    start_val = 1'b0;
  endtask

  // Start a batch and act as a coprocessor with random stalls, checking every
  // operand pair, the issue rule each cycle and the final batch state.
  task automatic run_batch(input logic [31:0] seed, input int cnt, input int stall_op,
                           input int stall_res, input logic exp_err, output logic [31:0] csum);
    logic [31:0] mgen, mcsum, prev_a, prev_b;
    logic [31:0] pend[$];
    logic        prev_stall, exp_val, iss_hs, res_hs;
    int          n_iss, n_rcv, cyc;
    mgen = seed; mcsum = 0; n_iss = 0; n_rcv = 0; cyc = 0;
    prev_stall = 1'b0; prev_a = 0; prev_b = 0;
    start_batch(seed, cnt);
    chk("done_after_start", {31'd0, done}, 32'd0);
    chk("result_rdy_run", {31'd0, result_rdy}, 32'd1);
    while (n_rcv < cnt && cyc < 5000) begin
      exp_val = (n_iss < cnt) && ((n_iss - n_rcv) < MAX_OUT);
      chk("op_val", {31'd0, operands_val}, {31'd0, exp_val});
      if (prev_stall) begin
        chk("hold_a", operands_bits_A, prev_a);
        chk("hold_b", operands_bits_B, prev_b);
      end
      operands_rdy = ($urandom_range(0, 99) >= stall_op);
      result_val   = (pend.size() > 0) && ($urandom_range(0, 99) >= stall_res);
      result_bits  = (pend.size() > 0) ? pend[0] : 32'd0;
      iss_hs = operands_val && operands_rdy;
      res_hs = result_val && result_rdy;
      if (iss_hs) begin
        chk("op_a", operands_bits_A, op_a(mgen));
        chk("op_b", operands_bits_B, op_b(mgen));
        pend.push_back(gcd_ref(op_a(mgen), op_b(mgen)));
        mgen = lcg_next(mgen);
        n_iss++;
      end
      if (res_hs) begin
        mcsum = fold(mcsum, pend.pop_front());
        n_rcv++;
      end
      prev_stall = operands_val && !operands_rdy;
      prev_a = operands_bits_A;
      prev_b = operands_bits_B;
      tick();
      cyc++;
    end
    operands_rdy = 1'b0;
    result_val   = 1'b0;
    if (n_rcv < cnt) chk("timeout", 32'(n_rcv), 32'(cnt));
    chk("done", {31'd0, done}, 32'd1);
    chk("checksum", checksum, mcsum);
    chk("issued", {16'd0, issued}, 32'(cnt));
    chk("received", {16'd0, received}, 32'(cnt));
    chk("err", {31'd0, err}, {31'd0, exp_err});
    chk("op_val_done", {31'd0, operands_val}, 32'd0);
    csum = mcsum;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_start_rdy"}, {31'd0, start_rdy}, 32'd1);
    chk({tag, "_op_val"}, {31'd0, operands_val}, 32'd0);
    chk({tag, "_res_rdy"}, {31'd0, result_rdy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_checksum"}, checksum, 32'd0);
    chk({tag, "_issued"}, {16'd0, issued}, 32'd0);
    chk({tag, "_received"}, {16'd0, received}, 32'd0);
  endtask

  initial begin
    logic [31:0] cs, cs_clean, mgen, first_res;
    logic [31:0] q[$];
    int          n_iss;

    idle_inputs();
    reset = 1'b1;
    repeat (3) tick();
    check_reset_values("reset");
    reset = 1'b0;
    tick();

    // Zero count: done one cycle after start, no traffic.
    start_batch(32'h1234_5678, 0);
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_checksum", checksum, 32'd0);
    chk("zero_op_val", {31'd0, operands_val}, 32'd0);
    chk("zero_start_rdy", {31'd0, start_rdy}, 32'd1);
    tick();

    // Single request from DONE: A=18, B=12, result 6.
    run_batch(32'h0C00_0012, 1, 0, 0, 1'b0, cs);
    chk("single_checksum", checksum, 32'h0000_0006);
    cs_clean = cs;

    // Full batches with random stalls on both sides.
    run_batch($urandom, 100, 40, 40, 1'b0, cs);
    run_batch($urandom, 37, 10, 70, 1'b0, cs);

    // Outstanding bound: no results returned -> exactly MAX_OUT issues.
    mgen = $urandom;
    start_batch(mgen, 20);
    operands_rdy = 1'b1;
    n_iss = 0;
    for (int i = 0; i < 8; i++) begin
      if (operands_val) begin
        q.push_back(gcd_ref(op_a(mgen), op_b(mgen)));
        mgen = lcg_next(mgen);
        n_iss++;
      end
      tick();
    end
    chk("bound_issues", 32'(n_iss), 32'd4);
    chk("bound_val", {31'd0, operands_val}, 32'd0);
    chk("bound_issued", {16'd0, issued}, 32'd4);
    first_res   = q.pop_front();
    result_val  = 1'b1;
    result_bits = first_res;
    tick();
    result_val = 1'b0;
    chk("slot_freed_val", {31'd0, operands_val}, 32'd1);
    chk("slot_a", operands_bits_A, op_a(mgen));
    tick();
    chk("slot_refilled_val", {31'd0, operands_val}, 32'd0);
    chk("slot_issued", {16'd0, issued}, 32'd5);
    chk("slot_received", {16'd0, received}, 32'd1);
    chk("slot_checksum", checksum, first_res);
    operands_rdy = 1'b0;

    // Reset mid-batch: outputs return to reset values without waiting for an edge.
    reset = 1'b1;
    #1;
    check_reset_values("midreset");
    tick();
    reset = 1'b0;
    tick();
    run_batch(32'h0C00_0012, 1, 0, 0, 1'b0, cs);
    chk("rerun_checksum", cs, cs_clean);
    chk("rerun_dut_checksum", checksum, 32'h0000_0006);

    // Error: a result in IDLE is refused and sets the sticky error.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    result_val  = 1'b1;
    result_bits = 32'h0000_0005;
    chk("err_res_rdy", {31'd0, result_rdy}, 32'd0);
    tick();
    result_val = 1'b0;
    chk("err_set", {31'd0, err}, 32'd1);
    chk("err_received", {16'd0, received}, 32'd0);
    run_batch($urandom, 7, 30, 30, 1'b1, cs);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/gcd_traffic_gen.md
# gcd_traffic_gen

Requester-side driver for the GCD coprocessor's val/rdy operand and result interfaces. On a start command it issues a programmed number of pseudo-random operand pairs and keeps a bounded number of requests in flight. It accepts the results in order and folds them into an order-sensitive checksum. It sits at the upstream/downstream end of `gcd_coprocessor` in the test-chip top and is used for on-chip self-test and throughput measurement.

## Interface
- `W`, 32: data width; must match the coprocessor.
- `OPW`, 8: significant operand bits, 1..W/2. Bounds subtract-loop latency.
- `MAX_OUT`, 4: maximum outstanding requests, 1..15.
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `start_val` in 1: start command valid.
- `start_rdy` out 1: ready for a start command.
- `start_count` in 16: number of requests in the batch.
- `start_seed` in W: initial generator state.
- `operands_val` out 1: operand pair valid.
- `operands_bits_A` out W: operand A.
- `operands_bits_B` out W: operand B.
- `operands_rdy` in 1: coprocessor accepts operands.
- `result_val` in 1: result valid.
- `result_bits` in W: GCD result.
- `result_rdy` out 1: ready to accept a result.
- `done` out 1: batch complete (level).
- `checksum` out W: result checksum.
- `err` out 1: sticky protocol error.
- `issued` out 16: requests issued this batch.
- `received` out 16: results received this batch.

## Operation
- **Reset values:** state IDLE; `start_rdy`=1; `operands_val`=0; `result_rdy`=0; `done`=0; `err`=0; `checksum`=0; `issued`=0; `received`=0; outstanding count=0; generator state `gen`=0.
- **States:** IDLE, RUN, DONE. `start_rdy` = (IDLE or DONE).
- **Start:** a start handshake (`start_val` & `start_rdy`) latches `count`←`start_count` and `gen`←`start_seed`, and clears `checksum`, `issued`, `received`, outstanding and `done`. `err` is not cleared; only reset clears it. Next state is RUN, or DONE if `start_count`==0.
- **Operands:** `operands_bits_A` = zero-extended `gen[OPW-1:0]`; `operands_bits_B` = zero-extended `gen[W-1:W-OPW]`.
- **Issue:** `operands_val` = RUN & (`issued` < `count`) & (outstanding < `MAX_OUT`).
  - On an issue handshake: `gen` ← `gen`*32'd1664525 + 32'd1013904223, truncated mod 2^W; `issued`++; outstanding++.
  - A/B/val never change while `operands_val`=1 and `operands_rdy`=0.
- **Receive:** `result_rdy` = RUN.
  - On a result handshake: `checksum` ← {`checksum[W-2:0]`, `checksum[W-1]`} ^ `result_bits`; `received`++; outstanding--.
  - If issue and receive occur in the same cycle, outstanding is unchanged.
- **Completion:** the result handshake that makes `received`==`count` moves RUN→DONE. `done`=1 in DONE.
- **Errors:** `result_val`=1 while outstanding==0 sets `err`. In IDLE/DONE the result is not accepted (`result_rdy`=0). `err` holds until reset.
- **Restart:** a new start from DONE begins a fresh batch; `done` drops the cycle after the start handshake.
- **Reset mid-batch:** everything returns to reset values immediately. The coprocessor shares `reset`, so its FIFOs flush too; no stale results arrive.

## Timing
- All state, counters and outputs are registered. `operands_val`, `result_rdy` and `start_rdy` are combinational from registered state only; there is no combinational path from inputs to outputs.
- Start handshake in cycle N → state RUN and first `operands_val` in cycle N+1, given `count`>0.
- Back-to-back issues at 1 per cycle while `operands_rdy`=1 and the outstanding limit is not reached.
- The outstanding limit is evaluated on registered outstanding, so a result accepted in cycle N frees a slot in cycle N+1.
- Last result accepted in cycle M → `done`=1 and final `checksum` visible in cycle M+1.
- `count`==0: start in cycle N → `done`=1 in cycle N+1. No operand traffic.

## Test plan
- **Single request:** seed 0x0C000012, count 1, ideal coprocessor → A=18, B=12 issued in cycle N+1; result 6; `done`=1; `checksum`=0x00000006; `issued`=`received`=1.
- **Outstanding bound:** count 10, `operands_rdy`=1, `result_val` held 0 → exactly 4 issues, then `operands_val`=0. Releasing one result allows exactly one more issue the next cycle.
- **Full batch:** count 100 with random `operands_rdy`/`result_val` stalls → A/B sequence and final `checksum` match the LCG + rotate-XOR model bit-exactly; operands are stable during every stall.
- **Zero count:** count 0 → `done`=1 one cycle after start; `checksum`=0; no `operands_val`.
- **Error detection:** `result_val`=1 in IDLE → `err`=1, `result_rdy`=0; `err` persists across a subsequent start.
- **Reset mid-batch:** reset asserted mid-batch, e.g. at `issued`=5 of count 20 → all outputs at reset values within the same cycle. A new batch after reset reproduces the results of a clean run.
